// File: rtl/im_port_arbiter_pkg.sv
// Shared types and memory geometry for the instruction-memory port arbiter.
package im_arb_pkg;
    localparam int IM_ADDR_W = 10;
    localparam int IM_DATA_W = 32;

    typedef enum logic {S_LOAD, S_RUN} arb_state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_LDR} owner_t;
endpackage

// File: rtl/im_port_arbiter_if.sv
// Fetch, loader and instruction-memory signals of the arbiter; slave = arbiter side.
import im_arb_pkg::*;

interface im_port_arbiter_if #(
    parameter int ADDR_W = IM_ADDR_W,
    parameter int DATA_W = IM_DATA_W
);
    logic              f_req, f_gnt, f_rvalid;
    logic [ADDR_W-1:0] f_addr;
    logic [DATA_W-1:0] f_rdata;
    logic              l_req, l_we, l_gnt, l_rvalid, l_done;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_wdata, l_rdata;
    logic              run;
    logic [ADDR_W:0]   wr_count;
    logic              im_enable, im_read, im_write;
    logic [ADDR_W-1:0] im_address;
    logic [DATA_W-1:0] im_in, im_out;

    modport slave (
        input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, l_done, im_out,
        output f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata, run, wr_count,
               im_enable, im_read, im_write, im_address, im_in
    );

    modport master (
        output f_req, f_addr, l_req, l_we, l_addr, l_wdata, l_done, im_out,
        input  f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata, run, wr_count,
               im_enable, im_read, im_write, im_address, im_in
    );
endinterface

// File: rtl/im_port_arbiter_rr_arb2.sv
// Two-requester round-robin picker; req[0]=fetch, req[1]=loader.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    // Reset to "loader last" so fetch wins the first contest.
    logic last_ldr;

    assign gnt[0] = en & req[0] & (~req[1] | last_ldr);
    assign gnt[1] = en & req[1] & (~req[0] | ~last_ldr);

    always_ff @(posedge clk) begin
        if (rst)         last_ldr <= 1'b1;
        else if (gnt[0]) last_ldr <= 1'b0;
        else if (gnt[1]) last_ldr <= 1'b1;
    end
endmodule

// File: rtl/im_port_arbiter.sv
// Shares the single instruction-memory port between fetch and the program loader.
import im_arb_pkg::*;

module im_port_arbiter #(
    parameter int ADDR_W = IM_ADDR_W,
    parameter int DATA_W = IM_DATA_W
) (
    input logic              clk,
    input logic              rst,
    im_port_arbiter_if.slave bus
);
    arb_state_t      state, state_nxt;
    owner_t          owner, owner_nxt;
    logic [ADDR_W:0] wr_count;
    logic [1:0]      gnt;
    logic            arb_en;

    assign arb_en = ~rst;

    // Fetch is masked while the program is still being loaded.
    rr_arb2 u_rr (
        .clk (clk),
        .rst (rst),
        .en  (arb_en),
        .req ({bus.l_req, bus.f_req & (state == S_RUN)}),
        .gnt (gnt)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_LOAD;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == S_LOAD && bus.l_done) state_nxt = S_RUN;
    end

    // Owner of the read whose data lands on im_out next cycle.
    always_comb begin
        owner_nxt = OWN_NONE;
        if (gnt[0])                   owner_nxt = OWN_FETCH;
        else if (gnt[1] & ~bus.l_we)  owner_nxt = OWN_LDR;
    end

    always_ff @(posedge clk) begin
        if (rst) owner <= OWN_NONE;
        else     owner <= owner_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst)
            wr_count <= '0;
        else if (gnt[1] & bus.l_we & ~(&wr_count))
            wr_count <= wr_count + 1'b1;
    end

    always_comb begin
        bus.im_enable  = 1'b0;
        bus.im_read    = 1'b0;
        bus.im_write   = 1'b0;
        bus.im_address = '0;
        bus.im_in      = {DATA_W{1'b0}};
        if (gnt[0]) begin
            bus.im_enable  = 1'b1;
            bus.im_read    = 1'b1;
            bus.im_address = bus.f_addr;
        end else if (gnt[1]) begin
            bus.im_enable  = 1'b1;
            bus.im_read    = ~bus.l_we;
            bus.im_write   = bus.l_we;
            bus.im_address = bus.l_addr;
            bus.im_in      = bus.l_wdata;
        end
    end

    assign bus.f_gnt    = gnt[0];
    assign bus.l_gnt    = gnt[1];
    assign bus.f_rvalid = (owner == OWN_FETCH);
    assign bus.l_rvalid = (owner == OWN_LDR);
    assign bus.f_rdata  = bus.im_out;
    assign bus.l_rdata  = bus.im_out;
    assign bus.run      = (state == S_RUN);
    assign bus.wr_count = wr_count;
endmodule

// File: tb/tb_im_port_arbiter.sv
// Directed bench for im_port_arbiter with a behavioural 1024x32 1-cycle-latency memory.
module tb_im_port_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [31:0] mem [0:1023];

    im_port_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus ();

    im_port_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.im_enable) begin
            if (bus.im_write) mem[bus.im_address] <= bus.im_in;
            if (bus.im_read)  bus.im_out <= mem[bus.im_address];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.im_out = '0;
        rst = 1'b1;
        bus.f_req = 1'b1; bus.f_addr = '0;
        bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_addr = '0; bus.l_wdata = '0;
        bus.l_done = 1'b0;
        #1;
        chk("rst_f_gnt", bus.f_gnt, 0);
        chk("rst_l_gnt", bus.l_gnt, 0);
        chk("rst_im_enable", bus.im_enable, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; bus.f_req = 1'b0; bus.l_req = 1'b0;
        #1;
        chk("reset_run", bus.run, 0);
        chk("reset_f_rvalid", bus.f_rvalid, 0);
        chk("reset_l_rvalid", bus.l_rvalid, 0);
        chk("reset_wr_count", bus.wr_count, 0);

        // LOAD: loader writes 0..3 while fetch is held off
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_addr = 10'(i); bus.l_wdata = 32'hA0 + 32'(i);
            bus.f_req = 1'b1; bus.f_addr = '0;
            #1;
            chk("load_f_gnt", bus.f_gnt, 0);
            chk("load_l_gnt", bus.l_gnt, 1);
            chk("load_im_write", bus.im_write, 1);
            chk("load_im_address", bus.im_address, i);
        end
        @(negedge clk);
        bus.l_req = 1'b0; bus.f_req = 1'b0; bus.l_done = 1'b1;
        #1;
        chk("load_wr_count", bus.wr_count, 4);
        chk("load_run", bus.run, 0);
        chk("load_l_rvalid", bus.l_rvalid, 0);
        @(posedge clk); #1;
        chk("done_run", bus.run, 1);

        // RUN: uncontested fetch of addr 2
        @(negedge clk);
        bus.l_done = 1'b0; bus.f_req = 1'b1; bus.f_addr = 10'd2;
        #1;
        chk("f2_gnt", bus.f_gnt, 1);
        chk("f2_im_read", bus.im_read, 1);
        chk("f2_im_address", bus.im_address, 2);
        @(posedge clk); #1;
        chk("f2_rvalid", bus.f_rvalid, 1);
        chk("f2_rdata", bus.f_rdata, 32'hA2);
        chk("f2_l_rvalid", bus.l_rvalid, 0);

        // uncontested loader read-back of addr 0
        @(negedge clk);
        bus.f_req = 1'b0; bus.l_req = 1'b1; bus.l_we = 1'b0; bus.l_addr = 10'd0;
        #1;
        chk("l0_gnt", bus.l_gnt, 1);
        chk("l0_im_write", bus.im_write, 0);
        @(posedge clk); #1;
        chk("l0_rvalid", bus.l_rvalid, 1);
        chk("l0_rdata", bus.l_rdata, 32'hA0);
        chk("l0_f_rvalid", bus.f_rvalid, 0);

        // contested: loader was last, so F,L,F,L
        @(negedge clk);
        bus.f_req = 1'b1; bus.f_addr = 10'd3;
        bus.l_req = 1'b1; bus.l_we = 1'b0; bus.l_addr = 10'd1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_f_gnt", bus.f_gnt, (k % 2 == 0));
            chk("rr_l_gnt", bus.l_gnt, (k % 2 == 1));
            @(posedge clk); #1;
            chk("rr_f_rvalid", bus.f_rvalid, (k % 2 == 0));
            chk("rr_l_rvalid", bus.l_rvalid, (k % 2 == 1));
            if (k % 2 == 0) chk("rr_f_rdata", bus.f_rdata, 32'hA3);
            else            chk("rr_l_rdata", bus.l_rdata, 32'hA1);
            @(negedge clk);
        end

        // write then immediate fetch of the same word
        bus.f_req = 1'b0; bus.l_req = 1'b1; bus.l_we = 1'b1;
        bus.l_addr = 10'd5; bus.l_wdata = 32'hDEADBEEF;
        #1;
        chk("w5_l_gnt", bus.l_gnt, 1);
        chk("w5_im_write", bus.im_write, 1);
        @(posedge clk); #1;
        chk("w5_wr_count", bus.wr_count, 5);
        chk("w5_l_rvalid", bus.l_rvalid, 0);
        @(negedge clk);
        bus.l_req = 1'b0; bus.f_req = 1'b1; bus.f_addr = 10'd5;
        @(posedge clk); #1;
        chk("f5_rvalid", bus.f_rvalid, 1);
        chk("f5_rdata", bus.f_rdata, 32'hDEADBEEF);

        // reset with a fetch read in flight
        @(negedge clk);
        bus.f_addr = 10'd2;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_im_enable", bus.im_enable, 0);
        chk("mid_rst_f_gnt", bus.f_gnt, 0);
        @(posedge clk); #1;
        chk("mid_rst_f_rvalid", bus.f_rvalid, 0);
        chk("mid_rst_run", bus.run, 0);
        chk("mid_rst_wr_count", bus.wr_count, 0);
        @(negedge clk);
        rst = 1'b0; bus.f_req = 1'b0;
        #1;
        chk("post_rst_f_rvalid", bus.f_rvalid, 0);

        // l_done together with a loader write
        bus.l_done = 1'b1; bus.l_req = 1'b1; bus.l_we = 1'b1;
        bus.l_addr = 10'd7; bus.l_wdata = 32'h1234;
        #1;
        chk("d7_l_gnt", bus.l_gnt, 1);
        @(posedge clk); #1;
        chk("d7_wr_count", bus.wr_count, 1);
        chk("d7_run", bus.run, 1);
        @(negedge clk);
        bus.l_done = 1'b0; bus.l_req = 1'b0; bus.f_req = 1'b1; bus.f_addr = 10'd7;
        @(posedge clk); #1;
        chk("f7_rvalid", bus.f_rvalid, 1);
        chk("f7_rdata", bus.f_rdata, 32'h1234);

        // wr_count saturation at 2047
        @(negedge clk);
        bus.f_req = 1'b0; bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_wdata = 32'h0;
        for (int i = 0; i < 2046; i++) begin
            bus.l_addr = 10'(i);
            @(negedge clk);
        end
        chk("sat_reach", bus.wr_count, 2047);
        @(negedge clk);
        chk("sat_hold", bus.wr_count, 2047);
        bus.l_we = 1'b0;
        @(negedge clk);
        chk("sat_read_not_counted", bus.wr_count, 2047);
        bus.l_req = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
